// File: rtl/color_dither.sv
// Two-stage temporal/spatial dither of 3-bit RGB levels down to 1-bit VGA drive.
// Latency 2 cycles, one pixel per cycle, no backpressure (never stalls).
module color_dither (
    input  logic       clk,
    input  logic       reset,
    input  logic       frameStart,
    input  logic       videoOn,
    input  logic       pixelOn,
    input  logic       xLsb,
    input  logic       yLsb,
    input  logic [8:0] charRgbDepth,
    input  logic [8:0] bckRgbDepth,
    output logic       red,
    output logic       green,
    output logic       blue
);

    logic [8:0] char_shadow_q, char_shadow_d;
    logic [8:0] bck_shadow_q,  bck_shadow_d;
    logic [2:0] frame_cnt_q,   frame_cnt_d;

    logic [8:0] s1_depth_q, s1_depth_d;
    logic       s1_vld_q,   s1_vld_d;
    logic [2:0] s1_phase_q, s1_phase_d;

    logic [2:0] rgb_q, rgb_d;

    // Level 7 is always on; otherwise the channel is lit for `level` of the 8 phases.
    function automatic logic chan_lit(input logic [2:0] level, input logic [2:0] phase);
        return (level == 3'd7) || (level > phase);
    endfunction

    always_comb begin
        char_shadow_d = char_shadow_q;
        bck_shadow_d  = bck_shadow_q;
        frame_cnt_d   = frame_cnt_q;
        if (frameStart) begin
            char_shadow_d = charRgbDepth;
            bck_shadow_d  = bckRgbDepth;
            frame_cnt_d   = frame_cnt_q + 3'd1;
        end
    end

    always_comb begin
        s1_depth_d = pixelOn ? char_shadow_q : bck_shadow_q;
        s1_vld_d   = videoOn;
        s1_phase_d = frame_cnt_q + {1'b0, yLsb, xLsb};
    end

    always_comb begin
        rgb_d = 3'b000;
        if (s1_vld_q) begin
            for (int ch = 0; ch < 3; ch++) begin
                rgb_d[ch] = chan_lit(s1_depth_q[3*ch +: 3], s1_phase_q);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            char_shadow_q <= 9'd0;
            bck_shadow_q  <= 9'd0;
            frame_cnt_q   <= 3'd0;
            s1_depth_q    <= 9'd0;
            s1_vld_q      <= 1'b0;
            s1_phase_q    <= 3'd0;
            rgb_q         <= 3'b000;
        end else begin
            char_shadow_q <= char_shadow_d;
            bck_shadow_q  <= bck_shadow_d;
            frame_cnt_q   <= frame_cnt_d;
            s1_depth_q    <= s1_depth_d;
            s1_vld_q      <= s1_vld_d;
            s1_phase_q    <= s1_phase_d;
            rgb_q         <= rgb_d;
        end
    end

    assign red   = rgb_q[0];
    assign green = rgb_q[1];
    assign blue  = rgb_q[2];

endmodule

// File: tb/tb_color_dither.sv
// Bench for color_dither: directed scenarios plus random traffic against a frame-level reference model.
module tb_color_dither;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frameStart = 1'b0;
    logic       videoOn = 1'b0;
    logic       pixelOn = 1'b0;
    logic       xLsb = 1'b0;
    logic       yLsb = 1'b0;
    logic [8:0] charRgbDepth = 9'd0;
    logic [8:0] bckRgbDepth = 9'd0;
    logic       red, green, blue;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: what the shadows and frame count should be.
    logic [8:0] m_char = 9'd0;
    logic [8:0] m_bck  = 9'd0;
    int         m_frame = 0;
    logic [2:0] prev_exp = 3'b000;

    color_dither dut (
        .clk          (clk),
        .reset        (reset),
        .frameStart   (frameStart),
        .videoOn      (videoOn),
        .pixelOn      (pixelOn),
        .xLsb         (xLsb),
        .yLsb         (yLsb),
        .charRgbDepth (charRgbDepth),
        .bckRgbDepth  (bckRgbDepth),
        .red          (red),
        .green        (green),
        .blue         (blue)
    );

    always #5 clk = ~clk;

    // Expected {blue,green,red} for a pixel, using the frame state in force when it is presented.
    function automatic logic [2:0] ref_rgb(input logic vo, input logic po, input logic x, input logic y);
        int depth, phase, level;
        logic [2:0] r;
        depth = po ? int'(m_char) : int'(m_bck);
        phase = (m_frame + 2 * int'(y) + int'(x)) % 8;
        for (int ch = 0; ch < 3; ch++) begin
            level = (depth >> (3 * ch)) % 8;
            r[ch] = vo && ((level == 7) || (level > phase));
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed rgb=%b expected rgb=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_char   = 9'd0;
        m_bck    = 9'd0;
        m_frame  = 0;
        prev_exp = 3'b000;
    endtask

    // Drive one pixel, clock it, then check the output produced by the previous pixel.
    task automatic cycle(input logic fs, input logic vo, input logic po, input logic x, input logic y,
                         input logic [8:0] cd, input logic [8:0] bd, input string tag,
                         output logic [2:0] obs);
        logic [2:0] e;
        frameStart   = fs;
        videoOn      = vo;
        pixelOn      = po;
        xLsb         = x;
        yLsb         = y;
        charRgbDepth = cd;
        bckRgbDepth  = bd;
        e = ref_rgb(vo, po, x, y);
        if (fs && reset) begin
            m_char  = cd;
            m_bck   = bd;
            m_frame = (m_frame + 1) % 8;
        end
        @(posedge clk);
        #1;
        obs = {blue, green, red};
        check(tag, obs, prev_exp);
        prev_exp = reset ? e : 3'b000;
    endtask

    initial begin
        logic [2:0]  o;
        logic [7:0]  mask;
        logic [3:0]  smask;
        logic [31:0] rnd;
        logic [8:0]  rc, rb;

        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {blue, green, red}, 3'b000);
        reset = 1'b1;
        model_reset();

        // Latency and select
        cycle(1, 0, 0, 0, 0, 9'o777, 9'o000, "sel_load", o);
        cycle(0, 1, 1, 0, 0, 9'o777, 9'o000, "sel_p1", o);
        cycle(0, 1, 0, 0, 0, 9'o777, 9'o000, "sel_p0", o);
        check("sel_out1", o, 3'b111);
        cycle(0, 1, 1, 0, 0, 9'o777, 9'o000, "sel_p1b", o);
        check("sel_out2", o, 3'b000);
        cycle(0, 0, 0, 0, 0, 9'o777, 9'o000, "sel_idle", o);
        check("sel_out3", o, 3'b111);

        // Temporal duty: red level 3 over all 8 frame counts
        mask = 8'h00;
        for (int f = 0; f < 8; f++) begin
            int fc;
            cycle(1, 0, 0, 0, 0, 9'o003, 9'o000, "duty_fs", o);
            fc = m_frame;
            cycle(0, 1, 1, 0, 0, 9'o003, 9'o000, "duty_px", o);
            cycle(0, 0, 0, 0, 0, 9'o003, 9'o000, "duty_obs", o);
            mask[fc] = o[0];
        end
        check("duty_cnt012", {2'b00, mask === 8'b0000_0111}, 3'b001);

        // Spatial offset: red level 1 at frameCnt 0
        do begin
            cycle(1, 0, 0, 0, 0, 9'o001, 9'o000, "spat_fs", o);
        end while (m_frame != 0);
        smask = 4'h0;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] xy;
            xy = 2'(i);
            cycle(0, 1, 1, xy[0], xy[1], 9'o001, 9'o000, "spat_px", o);
            if (i > 0) smask[i-1] = o[0];
        end
        cycle(0, 0, 0, 0, 0, 9'o001, 9'o000, "spat_obs", o);
        smask[3] = o[0];
        check("spat_only00", {2'b00, smask === 4'b0001}, 3'b001);

        // Wrap: starting at frameCnt 0, level 1 at xy=00 lights only after the 8th pulse
        mask = 8'h00;
        for (int p = 0; p < 8; p++) begin
            cycle(1, 0, 0, 0, 0, 9'o001, 9'o000, "wrap_fs", o);
            cycle(0, 1, 1, 0, 0, 9'o001, 9'o000, "wrap_px", o);
            cycle(0, 0, 0, 0, 0, 9'o001, 9'o000, "wrap_obs", o);
            mask[p] = o[0];
        end
        check("wrap_8th", {2'b00, mask === 8'b1000_0000}, 3'b001);

        // Blanking
        cycle(1, 0, 0, 0, 0, 9'o777, 9'o777, "blank_fs", o);
        cycle(0, 0, 1, 0, 0, 9'o777, 9'o777, "blank_a", o);
        cycle(0, 0, 0, 1, 1, 9'o777, 9'o777, "blank_b", o);
        check("blank_out_a", o, 3'b000);
        cycle(0, 1, 1, 0, 0, 9'o777, 9'o777, "blank_c", o);
        check("blank_out_b", o, 3'b000);
        cycle(0, 0, 0, 0, 0, 9'o777, 9'o777, "blank_d", o);
        check("blank_on", o, 3'b111);

        // Shadow timing
        cycle(1, 0, 0, 0, 0, 9'o000, 9'o000, "shd_fs0", o);
        cycle(0, 1, 1, 0, 0, 9'o777, 9'o000, "shd_mid", o);
        cycle(0, 1, 1, 0, 0, 9'o777, 9'o000, "shd_mid2", o);
        check("shd_mid_out", o, 3'b000);
        cycle(1, 1, 1, 0, 0, 9'o777, 9'o000, "shd_fs1", o);
        check("shd_mid2_out", o, 3'b000);
        cycle(0, 1, 1, 0, 0, 9'o777, 9'o000, "shd_after", o);
        check("shd_same_cycle", o, 3'b000);
        cycle(0, 0, 0, 0, 0, 9'o777, 9'o000, "shd_obs", o);
        check("shd_new", o, 3'b111);

        // Asynchronous reset with outputs lit
        cycle(0, 1, 1, 0, 0, 9'o777, 9'o000, "rst_pre", o);
        cycle(0, 1, 1, 0, 0, 9'o777, 9'o000, "rst_pre2", o);
        check("rst_lit", o, 3'b111);
        #3;
        reset = 1'b0;
        #1;
        check("rst_async", {blue, green, red}, 3'b000);
        model_reset();
        repeat (3) cycle(0, 1, 1, 0, 0, 9'o777, 9'o777, "rst_hold", o);
        reset = 1'b1;
        repeat (3) cycle(0, 1, 1, 0, 0, 9'o777, 9'o777, "rst_black", o);
        check("rst_black_out", o, 3'b000);
        cycle(1, 1, 1, 0, 0, 9'o777, 9'o777, "rst_fs", o);
        cycle(0, 1, 1, 0, 0, 9'o777, 9'o777, "rst_px", o);
        check("rst_before_fs", o, 3'b000);
        cycle(0, 1, 1, 0, 0, 9'o777, 9'o777, "rst_px2", o);
        check("rst_after_fs", o, 3'b111);

        // Random traffic, including back-to-back frame pulses
        for (int k = 0; k < 3000; k++) begin
            rnd = $urandom;
            rc  = 9'($urandom);
            rb  = 9'($urandom);
            cycle(rnd[7:4] == 4'd0 || rnd[15:8] == 8'd1, rnd[0] | rnd[16], rnd[1], rnd[2], rnd[3],
                  rc, rb, "rand", o);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
